io_device_responder: RTL and testbench

Device-side responder for the CPU's memory-mapped IO path. It decodes IO load/store cycles by address and owns the board peripheral state:
- a 16-bit LED register
- a synchronised, debounced 16-bit switch input
- an 8-digit multiplexed seven-segment display with a per-digit enable mask

It sits between the CPU's memory/IO routing logic and the board pins. It returns switch/LED data on IO loads and latches store data on IO stores.

---
 rtl/io_map_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 14 +
 rtl/io_device_responder.sv | 119 +++++++++++
 tb/tb_io_device_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - IO address map and seven-segment glyph constants
// Shared by the CPU top, io_device_responder and the bench.
//   IO_ADDR_*   : exact 32-bit IO register addresses
//   SEG_BLANK   : all segments off (active-low)
//   HEX7_TABLE  : hex glyphs {g,f,e,d,c,b,a}, active-low, index = nibble
package io_map_pkg;

    localparam logic [31:0] IO_ADDR_LED   = 32'hFFFF_FC60;
    localparam logic [31:0] IO_ADDR_SW    = 32'hFFFF_FC70;
    localparam logic [31:0] IO_ADDR_SEG   = 32'hFFFF_FC80;
    localparam logic [31:0] IO_ADDR_SEGEN = 32'hFFFF_FC84;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed, so the leftmost entry is index 15 (F) and the rightmost is 0.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - hex nibble to active-low seven-segment pattern
// Ports:
//   nibble   in  4  hex digit value
//   segments out 7  {g,f,e,d,c,b,a}, active-low
module seg7_decoder
    import io_map_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = HEX7_TABLE[nibble];

endmodule

// File: rtl/io_device_responder.sv
// rtl/io_device_responder.sv - memory-mapped IO responder for LEDs, switches, 7-seg
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   io_read, io_write        single-cycle IO load / store strobes
//   addr, write_data         byte address and store data from the CPU
//   io_read_data             combinational load data (switches or LEDs)
//   switch_in                raw asynchronous board switches
//   led_out                  LED register, active-high
//   seg_an, seg_out, seg_dp  multiplexed display drive, all active-low
module io_device_responder
    import io_map_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          SCAN_DIV        = 100_000,
    parameter logic [31:0] ADDR_LED        = IO_ADDR_LED,
    parameter logic [31:0] ADDR_SW         = IO_ADDR_SW,
    parameter logic [31:0] ADDR_SEG        = IO_ADDR_SEG,
    parameter logic [31:0] ADDR_SEGEN      = IO_ADDR_SEGEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [15:0] io_read_data,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [7:0]  seg_an,
    output logic [6:0]  seg_out,
    output logic        seg_dp
);

    // Widths stay at least one bit so a parameter of 1 still elaborates.
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    logic [31:0]       seg_value;
    logic [7:0]        seg_en;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic [15:0]       sw_cand;
    logic [15:0]       sw_stable;
    logic [DEB_W-1:0]  deb_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit_idx;
    logic [7:0]        digit_sel;
    logic [6:0]        digit_glyph;

    assign digit_sel = 8'h01 << digit_idx;
    assign seg_dp    = 1'b1;

    seg7_decoder u_seg7_decoder (
        .nibble   (seg_value[{digit_idx, 2'b00} +: 4]),
        .segments (digit_glyph)
    );

    // Zero-latency read so a single-cycle load completes; sees pre-edge state.
    always_comb begin
        io_read_data = 16'h0000;
        if (io_read) begin
            if (addr == ADDR_SW) begin
                io_read_data = sw_stable;
            end else if (addr == ADDR_LED) begin
                io_read_data = led_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out   <= 16'h0000;
            seg_value <= 32'h0;
            seg_en    <= 8'hFF;
            sw_meta   <= 16'h0;
            sw_sync   <= 16'h0;
            sw_cand   <= 16'h0;
            sw_stable <= 16'h0;
            deb_cnt   <= '0;
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            seg_an    <= 8'hFF;
            seg_out   <= SEG_BLANK;
        end else begin
            if (io_write) begin
                if (addr == ADDR_LED)   led_out   <= write_data[15:0];
                if (addr == ADDR_SEG)   seg_value <= write_data;
                if (addr == ADDR_SEGEN) seg_en    <= write_data[7:0];
            end

            sw_meta <= switch_in;
            sw_sync <= sw_meta;

            // Whole-vector debounce: any bit change restarts the quiet period.
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
            if (deb_cnt == DEB_MAX) begin
                sw_stable <= sw_cand;
            end

            if (scan_cnt == SCAN_MAX) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            seg_an  <= ~(digit_sel & seg_en);
            seg_out <= seg_en[digit_idx] ? digit_glyph : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_io_device_responder.sv
// tb/tb_io_device_responder.sv - randomized bench with behavioural reference model
module tb_io_device_responder;

    localparam int DEB  = 4;
    localparam int SCAN = 3;
    localparam logic [31:0] A_LED   = 32'hFFFF_FC60;
    localparam logic [31:0] A_SW    = 32'hFFFF_FC70;
    localparam logic [31:0] A_SEG   = 32'hFFFF_FC80;
    localparam logic [31:0] A_SEGEN = 32'hFFFF_FC84;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_read;
    logic        io_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [15:0] io_read_data;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [7:0]  seg_an;
    logic [6:0]  seg_out;
    logic        seg_dp;

    always #5 clk = ~clk;

    io_device_responder #(
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_DIV        (SCAN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_read      (io_read),
        .io_write     (io_write),
        .addr         (addr),
        .write_data   (write_data),
        .io_read_data (io_read_data),
        .switch_in    (switch_in),
        .led_out      (led_out),
        .seg_an       (seg_an),
        .seg_out      (seg_out),
        .seg_dp       (seg_dp)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [15:0] m_led    = 16'h0;
    logic [31:0] m_segv   = 32'h0;
    logic [7:0]  m_en     = 8'hFF;
    logic [15:0] m_stable = 16'h0;
    logic [7:0]  m_an     = 8'hFF;
    logic [6:0]  m_out    = 7'h7F;
    int          m_cnt    = 0;       // non-reset edges since the last reset
    logic [15:0] m_samples [$];      // switch_in seen at each post-reset edge

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int shown_digit();
        return ((m_cnt - 1) / SCAN) % 8;
    endfunction

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        int d;
        int m;
        logic run;
        if (rst) begin
            m_led = 16'h0; m_segv = 32'h0; m_en = 8'hFF; m_stable = 16'h0;
            m_an = 8'hFF; m_out = 7'h7F; m_cnt = 0;
            m_samples.delete();
        end else begin
            m_cnt++;
            d = shown_digit();
            if (m_en[d]) begin
                m_an  = ~(8'h01 << d);
                m_out = hex_tab[(m_segv >> (4 * d)) & 32'hF];
            end else begin
                m_an  = 8'hFF;
                m_out = 7'h7F;
            end
            if (io_write && addr == A_LED)   m_led  = write_data[15:0];
            if (io_write && addr == A_SEG)   m_segv = write_data;
            if (io_write && addr == A_SEGEN) m_en   = write_data[7:0];
            // A value is accepted once DEB consecutive samples agree, becoming
            // visible three edges after the last of them (two sync stages plus
            // the stable register).
            m_samples.push_back(switch_in);
            if (m_samples.size() > DEB + 3) void'(m_samples.pop_front());
            if (m_samples.size() >= DEB + 3) begin
                m = m_samples.size() - 4;
                run = 1'b1;
                for (int k = m - DEB + 1; k < m; k++)
                    if (m_samples[k] != m_samples[m]) run = 1'b0;
                if (run) m_stable = m_samples[m];
            end
        end
    endtask

    // Inputs are set just after a falling edge; check read data, clock, check outputs.
    task automatic cycle();
        logic [15:0] exp_rd;
        #1;
        exp_rd = 16'h0;
        if (io_read && addr == A_SW)  exp_rd = m_stable;
        if (io_read && addr == A_LED) exp_rd = m_led;
        check("io_read_data", io_read_data, exp_rd);
        @(posedge clk);
        model_edge();
        #1;
        check("led_out", led_out, m_led);
        check("seg_an", seg_an, m_an);
        check("seg_out", seg_out, m_out);
        check("seg_dp", seg_dp, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; io_read = 1'b0; io_write = 1'b0; addr = 32'h0; write_data = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        idle(); io_write = 1'b1; addr = a; write_data = d;
        cycle();
    endtask

    task automatic rd(input logic [31:0] a);
        idle(); io_read = 1'b1; addr = a;
        cycle();
    endtask

    initial begin
        int hold;
        int sel;
        int guard;
        idle();
        switch_in = 16'h0;
        rst = 1'b1;
        @(negedge clk);

        // Reset
        cycle(); cycle();
        check("rst_led", led_out, 16'h0);
        check("rst_an", seg_an, 8'hFF);
        check("rst_seg", seg_out, 7'h7F);
        idle();
        cycle();
        check("first_an", seg_an, 8'hFE);
        check("first_seg", seg_out, 7'h40);

        // LED write / read
        wr(A_LED, 32'hABCD_1234);
        check("led_write", led_out, 16'h1234);
        rd(A_LED);
        rd(32'hFFFF_FC64);

        // Switch debounce, then a short glitch that must not be accepted
        switch_in = 16'h00A5;
        for (int i = 0; i < 10; i++) rd(A_SW);
        switch_in = 16'hFFFF;
        rd(A_SW); rd(A_SW);
        switch_in = 16'h00A5;
        for (int i = 0; i < 10; i++) rd(A_SW);
        idle(); io_read = 1'b1; addr = A_SW; #1;
        check("sw_after_glitch", io_read_data, 16'h00A5);
        cycle();

        // Display scan across a full rotation and the 7 -> 0 wrap
        wr(A_SEG, 32'h0123_89AF);
        wr(A_SEGEN, 32'h0000_000F);
        for (int i = 0; i < 30; i++) begin
            idle();
            cycle();
        end

        // Boundaries: writes to the switch address and unmapped space
        wr(A_SW, 32'h0000_FFFF);
        wr(32'hFFFF_FC64, 32'h0000_7777);
        wr(32'h0000_FC60, 32'h0000_6666);
        check("ignored_writes", led_out, 16'h1234);
        idle(); io_read = 1'b1; io_write = 1'b1; addr = A_LED; write_data = 32'h0000_5555; #1;
        check("same_cycle_rw", io_read_data, 16'h1234);
        cycle();
        check("same_cycle_w", led_out, 16'h5555);

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            idle();
            io_read  = 1'($urandom_range(0, 1));
            io_write = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 6);
            case (sel)
                0: addr = A_LED;
                1: addr = A_SW;
                2: addr = A_SEG;
                3: addr = A_SEGEN;
                4: addr = A_LED + 32'd4;
                5: addr = A_SW ^ (32'h1 << $urandom_range(0, 31));
                default: addr = $urandom;
            endcase
            write_data = $urandom;
            if (hold == 0) begin
                switch_in = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h00A5;
                hold = $urandom_range(1, 8);
            end
            hold--;
            cycle();
        end

        // Reset mid-scan at digit 5 with a colliding LED write
        wr(A_SEGEN, 32'h0000_00FF);
        guard = 0;
        while (shown_digit() != 5 && guard < 100) begin
            idle();
            cycle();
            guard++;
        end
        check("reach_digit5", 32'(shown_digit()), 32'd5);
        idle(); rst = 1'b1; io_write = 1'b1; addr = A_LED; write_data = 32'h0000_BEEF;
        cycle();
        check("midrst_led", led_out, 16'h0);
        check("midrst_an", seg_an, 8'hFF);
        check("midrst_seg", seg_out, 7'h7F);
        idle();
        cycle();
        check("midrst_first_an", seg_an, 8'hFE);
        check("midrst_first_seg", seg_out, 7'h40);
        for (int i = 0; i < 12; i++) rd(A_SW);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
